// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: one write port, two enable-gated read ports and a monitor port.
// The master drives requests and addresses; the slave (the bank) returns data and the wrap flag.
interface register_bank_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             wr_en;
    logic [1:0]       wr_op;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic             rd_en_a;
    logic [AW-1:0]    rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;

    logic             rd_en_b;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;

    logic [AW-1:0]    mon_addr;
    logic [WIDTH-1:0] mon_data;

    logic             wr_wrap;

    modport master (
        output wr_en, wr_op, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, mon_addr,
        input  rd_data_a, rd_data_b, mon_data, wr_wrap
    );

    modport slave (
        input  wr_en, wr_op, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, mon_addr,
        output rd_data_a, rd_data_b, mon_data, wr_wrap
    );
endinterface

// File: rtl/register_bank.sv
// Small register file / counter bank: one write port (load/inc/dec/clear), two gated read
// ports and an ungated monitor port, with optional forwarding of the in-flight write.
module register_bank #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 8,
    parameter bit               BYPASS      = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic           clk,
    input  logic           rst,
    register_bank_if.slave bus
);
    localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   NPORTS  = 3;
    // DEPTH always fits in AW+1 bits, so the range check needs one extra bit only.
    localparam logic [AW:0]   DEPTH_W = DEPTH[AW:0];

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef logic [WIDTH-1:0] word_t;

    word_t         mem_q [DEPTH];
    word_t         mem_d [DEPTH];
    logic          wrap_q;
    logic          wrap_d;

    logic          wr_valid;
    word_t         wr_cur;
    word_t         wr_next;

    logic [AW-1:0] port_addr [NPORTS];
    logic          port_en   [NPORTS];
    word_t         port_val  [NPORTS];

    // Write port: next value of the addressed entry and the wrap flag.
    always_comb begin
        wr_valid = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W);

        wr_cur = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (bus.wr_addr == AW'(i)) begin
                wr_cur = mem_q[i];
            end
        end

        wr_next = wr_cur;
        unique case (bus.wr_op)
            OP_LOAD: wr_next = bus.wr_data;
            OP_INC:  wr_next = wr_cur + word_t'(1);
            OP_DEC:  wr_next = wr_cur - word_t'(1);
            OP_CLR:  wr_next = '0;
        endcase

        wrap_d = wr_valid &&
                 (((bus.wr_op == OP_INC) && (&wr_cur)) ||
                  ((bus.wr_op == OP_DEC) && (wr_cur == '0)));

        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
            if (wr_valid && (bus.wr_addr == AW'(i))) begin
                mem_d[i] = wr_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= RESET_VALUE;
            end
            wrap_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            wrap_q <= wrap_d;
        end
    end

    // Read side: port 0 = A, 1 = B, 2 = monitor (always enabled).
    always_comb begin
        port_addr[0] = bus.rd_addr_a;
        port_addr[1] = bus.rd_addr_b;
        port_addr[2] = bus.mon_addr;
        port_en[0]   = bus.rd_en_a;
        port_en[1]   = bus.rd_en_b;
        port_en[2]   = 1'b1;

        for (int p = 0; p < int'(NPORTS); p++) begin
            port_val[p] = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (port_addr[p] == AW'(i)) begin
                    port_val[p] = mem_q[i];
                end
            end
            // wr_valid implies an in-range address, so forwarding never hits a missing entry.
            if (BYPASS && wr_valid && (port_addr[p] == bus.wr_addr)) begin
                port_val[p] = wr_next;
            end
            if (!port_en[p]) begin
                port_val[p] = '0;
            end
        end
    end

    assign bus.rd_data_a = port_val[0];
    assign bus.rd_data_b = port_val[1];
    assign bus.mon_data  = port_val[2];
    assign bus.wr_wrap   = wrap_q;
endmodule

// File: doc/register_bank.md
# register_bank

Parametrised bank of DEPTH registers, each WIDTH bits wide, with one write port and two enable-gated read ports. A third monitor port reads continuously, without an enable. The write port performs load, increment, decrement or clear on the addressed entry, and an optional bypass forwards the in-flight write to the reads. It replaces single-register storage where the datapath needs a small general-purpose register file or a bank of loop counters.

## Interface
- WIDTH, 8, data width of every entry (≥1)
- DEPTH, 8, number of entries (≥2)
- AW, max(1, clog2(DEPTH)), address width (derived; not overridden)
- BYPASS, 1, 1 = reads of the address being written return the next value; 0 = reads return the stored value
- RESET_VALUE, 0, WIDTH-bit value loaded into every entry on reset

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write-port operation request
- wr_op  in  2  operation: 00 load, 01 increment, 10 decrement, 11 clear
- wr_addr  in  AW  target entry
- wr_data  in  WIDTH  load data (used only when wr_op=00)
- rd_en_a  in  1  read port A enable
- rd_addr_a  in  AW  read port A address
- rd_data_a  out  WIDTH  port A data; 0 when disabled
- rd_en_b  in  1  read port B enable
- rd_addr_b  in  AW  read port B address
- rd_data_b  out  WIDTH  port B data; 0 when disabled
- mon_addr  in  AW  monitor address
- mon_data  out  WIDTH  monitor data, always driven
- wr_wrap  out  1  registered flag: previous accepted inc/dec wrapped

## Operation
- Storage: DEPTH × WIDTH flops. There is no other state except wr_wrap.
- Write, at the rising edge when wr_en=1 and wr_addr<DEPTH:
  - 00: entry ← wr_data
  - 01: entry ← entry+1 mod 2^WIDTH
  - 10: entry ← entry−1 mod 2^WIDTH
  - 11: entry ← 0. Clear writes 0, not RESET_VALUE.
- wr_wrap at each edge:
  - 1 if wr_en=1, address valid, and either wr_op=01 with entry all-ones, or wr_op=10 with entry 0.
  - Otherwise 0, including when wr_en=0. It is a one-cycle pulse per event and holds for repeated wrapping writes.
- wr_addr ≥ DEPTH: the write is ignored, no entry changes, wr_wrap=0.
- Reads are combinational from storage; all three ports are independent and may alias the same entry.
- rd_data_x: if rd_en_x=0 or rd_addr_x ≥ DEPTH, the port drives 0. Otherwise it drives the entry value, or the forwarded value under bypass.
- mon_data: the entry value, or the forwarded value under bypass; 0 if mon_addr ≥ DEPTH.
- Bypass (BYPASS=1): if wr_en=1 and wr_addr<DEPTH equals the read address, the port drives the value the entry will take at the next edge. This applies to all four ops, including inc/dec computed from the current entry.
- With BYPASS=0, reads always drive the currently stored value.
- Unknown/undefined ops cannot occur, since all four codes are defined.

## Timing
- Reset (rst=1, async):
  - All entries = RESET_VALUE immediately, no clock needed.
  - wr_wrap=0.
  - rd_data_a/b follow reset storage, so they read 0 if disabled and RESET_VALUE if enabled.
  - mon_data=RESET_VALUE.
- A write during reset is discarded. The first write accepted is at the first rising edge with rst=0.
- Reset asserted mid-operation wins over any same-cycle write.
- Write latency: 1 edge. Without bypass, the new value is visible on reads after the edge. With bypass, it is visible combinationally in the same cycle.
- Read latency: 0 cycles (combinational address → data).
- wr_wrap is valid in the cycle after the wrapping edge.
- Back-to-back writes to the same entry every cycle are legal. Each edge uses the value stored by the previous edge, so inc,inc → +2.

## Test plan
- Reset with RESET_VALUE=8'h5A, DEPTH=8: assert rst without a clock. Required: mon_data=8'h5A for every mon_addr; rd_data_a=0 with rd_en_a=0; wr_wrap=0.
- Load 8'h11..8'h88 to addresses 0..7, then read A=3 and B=6 simultaneously. Required: rd_data_a=8'h44, rd_data_b=8'h77. With rd_en_a dropped, rd_data_a=0.
- Inc/dec wrap:
  - Load 8'hFE to entry 2, then three increments. Required: entry values FF, 00, 01; wr_wrap high only in the cycle after the second increment.
  - Clear, then decrement. Required: entry=FF and wr_wrap=1 for one cycle.
- Bypass, with entry 4=8'h10 and wr_en=1, op=01, addr=4, rd_addr_a=4 in the same cycle:
  - BYPASS=1: rd_data_a=8'h11 before the edge.
  - BYPASS=0: rd_data_a=8'h10 before the edge and 8'h11 after it.
- Out-of-range, with DEPTH=6: write 8'hAA to address 7. Required: no entry changes; rd_addr_a=7 with rd_en_a=1 gives 0; wr_wrap=0.
- Reset mid-operation: increment entry 0 every cycle, then assert rst between edges. Required: entry 0 returns to RESET_VALUE at once. The first increment after release gives RESET_VALUE+1.
